// File: rtl/ins_cache_pkg.sv
// Shared constants for the instruction cache slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ins_cache_pkg;

    // Data/address width shared across the fetch path.
    localparam int DAT_W = 32;

    // Default index width for the instruction cache (2^IC_IDX_W entries).
    localparam int IC_IDX_W = 8;

endpackage : ins_cache_pkg

// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache, halfword-indexed, single outstanding fill.
// Latency: hit is combinational; a miss fills one cycle after mc_done_i.
// Backpressure: en low freezes FSM, request and storage; requests are ignored while a fill is pending.
module ins_cache
    import ins_cache_pkg::*;
#(
    parameter int IDX_W = IC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DAT_W-1:0] if_pc_i,
    input  logic             if_req_i,
    output logic             if_hit_o,
    output logic [DAT_W-1:0] if_ins_o,
    output logic             mc_req_o,
    output logic [DAT_W-1:0] mc_addr_o,
    input  logic             mc_done_i,
    input  logic [DAT_W-1:0] mc_data_i
);

    localparam int TAG_W   = DAT_W - IDX_W - 1;
    localparam int ENTRIES = 1 << IDX_W;

    // Two-state fill controller; encodings are local to this block.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DAT_W-1:0]   addr_q;
    logic [DAT_W-1:0]   addr_d;
    logic               fill;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [DAT_W-1:0]   data_mem [ENTRIES];

    logic [IDX_W-1:0]   look_idx;
    logic [TAG_W-1:0]   look_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    // Bit 0 of an address never selects an entry: PCs are halfword aligned.
    logic               unused_bits;
    assign unused_bits = if_pc_i[0] ^ addr_q[0];

    assign look_idx = if_pc_i[IDX_W:1];
    assign look_tag = if_pc_i[DAT_W-1:IDX_W+1];
    assign fill_idx = addr_q[IDX_W:1];
    assign fill_tag = addr_q[DAT_W-1:IDX_W+1];

    // Combinational lookup; data is presented regardless of hit.
    assign if_hit_o  = valid_q[look_idx] && (tag_mem[look_idx] == look_tag);
    assign if_ins_o  = data_mem[look_idx];

    // The outstanding request is exactly the WAIT state, so it drops with reset.
    assign mc_req_o  = (state_q == S_WAIT);
    assign mc_addr_o = addr_q;

    // FSM state and latched miss address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state: accept a miss in IDLE, complete the fill in WAIT; en low holds everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fill    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && if_req_i && !if_hit_o) begin
                    state_d = S_WAIT;
                    addr_d  = if_pc_i;
                end
            end
            S_WAIT: begin
                // A redirect does not cancel the fill: its data is right for its address.
                if (en && mc_done_i) begin
                    fill    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Valid bits are the only reset storage; a fill sets the bit at its index.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: a fill overwrites whatever occupied the index.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mc_data_i;
        end
    end

endmodule : ins_cache

// File: tb/tb_ins_cache.sv
// Testbench for ins_cache: directed vector table followed by randomized traffic against a reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: bench acts as both fetcher and memory controller.
module tb_ins_cache;
    import ins_cache_pkg::*;

    logic             clk;
    logic             rst;
    logic             en;
    logic [DAT_W-1:0] if_pc_i;
    logic             if_req_i;
    logic             if_hit_o;
    logic [DAT_W-1:0] if_ins_o;
    logic             mc_req_o;
    logic [DAT_W-1:0] mc_addr_o;
    logic             mc_done_i;
    logic [DAT_W-1:0] mc_data_i;

    int compared;
    int mismatched;

    ins_cache #(.IDX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .if_pc_i   (if_pc_i),
        .if_req_i  (if_req_i),
        .if_hit_o  (if_hit_o),
        .if_ins_o  (if_ins_o),
        .mc_req_o  (mc_req_o),
        .mc_addr_o (mc_addr_o),
        .mc_done_i (mc_done_i),
        .mc_data_i (mc_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        e;
        logic [31:0] pc;
        logic        rq;
        logic        dn;
        logic [31:0] dat;
        logic        x_hit;
        logic [31:0] x_ins;
        logic        chk_ins;
        logic        x_req;
        logic [31:0] x_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit e, logic [31:0] pc, bit rq, bit dn, logic [31:0] dat,
                               bit xh, logic [31:0] xi, bit ci, bit xr, logic [31:0] xa);
        vec_t t;
        t.r = r; t.e = e; t.pc = pc; t.rq = rq; t.dn = dn; t.dat = dat;
        t.x_hit = xh; t.x_ins = xi; t.chk_ins = ci; t.x_req = xr; t.x_addr = xa;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory contents: a fixed byte function of address; words are little-endian.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] t;
        t = (a * 32'd37) + (a >> 7);
        return t[7:0] ^ 8'h5c;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Reference model: each entry remembers which halfword address it holds.
    bit          m_valid [256];
    logic [30:0] m_hw    [256];
    bit          m_wait;
    logic [31:0] m_addr;

    function automatic bit model_hit(input logic [31:0] pc);
        int i;
        i = int'((pc >> 1) % 256);
        return m_valid[i] && (m_hw[i] == pc[31:1]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_wait = 1'b0;
        m_addr = '0;
    endtask

    initial begin
        int cnt;
        bit prev_miss;
        bit xh;
        int i;

        compared   = 0;
        mismatched = 0;
        rst = 1'b1; en = 1'b1; if_pc_i = '0; if_req_i = 1'b0; mc_done_i = 1'b0; mc_data_i = '0;

        // r, e, pc, req, done, data, x_hit, x_ins, chk_ins, x_req, x_addr
        vecs.push_back(v(0,1,32'h000,0,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h000,0,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h000,0,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h000,1,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h000,0,0,0,           0,0,0,           1,32'h000));
        vecs.push_back(v(0,1,32'h000,0,1,32'h00000513,0,0,0,           1,32'h000));
        vecs.push_back(v(0,1,32'h000,0,0,0,           1,32'h00000513,1,0,32'h000));
        vecs.push_back(v(0,1,32'h002,1,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h002,0,1,32'h45814501,0,0,0,           1,32'h002));
        vecs.push_back(v(0,1,32'h002,0,0,0,           1,32'h45814501,1,0,32'h002));
        vecs.push_back(v(0,1,32'h000,0,0,0,           1,32'h00000513,1,0,32'h002));
        vecs.push_back(v(0,1,32'h200,1,0,0,           0,0,0,           0,32'h002));
        vecs.push_back(v(0,1,32'h200,0,1,32'hAAAA5555,0,0,0,           1,32'h200));
        vecs.push_back(v(0,1,32'h200,0,0,0,           1,32'hAAAA5555,1,0,32'h200));
        vecs.push_back(v(0,1,32'h000,0,0,0,           0,0,0,           0,32'h200));
        vecs.push_back(v(0,1,32'h040,0,1,32'h0000DEAD,0,0,0,           0,32'h200));
        vecs.push_back(v(0,1,32'h040,0,0,0,           0,0,0,           0,32'h200));
        vecs.push_back(v(0,1,32'h040,1,0,0,           0,0,0,           0,32'h200));
        vecs.push_back(v(0,1,32'h100,0,0,0,           0,0,0,           1,32'h040));
        vecs.push_back(v(0,1,32'h100,1,0,0,           0,0,0,           1,32'h040));
        vecs.push_back(v(0,1,32'h100,0,1,32'h11112222,0,0,0,           1,32'h040));
        vecs.push_back(v(0,1,32'h040,0,0,0,           1,32'h11112222,1,0,32'h040));
        vecs.push_back(v(0,1,32'h100,1,0,0,           0,0,0,           0,32'h040));
        vecs.push_back(v(0,1,32'h100,0,0,0,           0,0,0,           1,32'h100));
        for (int k = 0; k < 5; k++)
            vecs.push_back(v(0,0,32'h100,1,0,0,       0,0,0,           1,32'h100));
        vecs.push_back(v(0,1,32'h100,0,1,32'h33334444,0,0,0,           1,32'h100));
        vecs.push_back(v(0,1,32'h100,0,0,0,           1,32'h33334444,1,0,32'h100));
        vecs.push_back(v(0,1,32'h080,1,0,0,           0,0,0,           0,32'h100));
        vecs.push_back(v(0,1,32'h080,0,0,0,           0,0,0,           1,32'h080));
        vecs.push_back(v(1,1,32'h080,0,0,0,           0,0,0,           1,32'h080));
        vecs.push_back(v(0,1,32'h100,0,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h000,0,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h002,0,0,0,           0,0,0,           0,32'h000));
        vecs.push_back(v(0,1,32'h200,0,0,0,           0,0,0,           0,32'h000));

        @(posedge clk);
        @(posedge clk);
        #1;

        // Directed table: one row per cycle.
        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].r; en = vecs[k].e; if_pc_i = vecs[k].pc;
            if_req_i = vecs[k].rq; mc_done_i = vecs[k].dn; mc_data_i = vecs[k].dat;
            @(negedge clk);
            chk($sformatf("tbl%0d hit", k), {31'd0, if_hit_o}, {31'd0, vecs[k].x_hit});
            chk($sformatf("tbl%0d mc_req", k), {31'd0, mc_req_o}, {31'd0, vecs[k].x_req});
            chk($sformatf("tbl%0d mc_addr", k), mc_addr_o, vecs[k].x_addr);
            if (vecs[k].chk_ins) chk($sformatf("tbl%0d ins", k), if_ins_o, vecs[k].x_ins);
            @(posedge clk);
            #1;
        end

        // Randomized traffic; the table ended in IDLE with everything invalidated by reset.
        model_reset();
        cnt = 0;
        prev_miss = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom % 400) == 0;
            en  = ($urandom % 10) != 0;
            if (prev_miss && ($urandom % 100) < 85) begin
                if_req_i = 1'b1;
            end else begin
                if (($urandom % 2) == 0)
                    if_pc_i = ($urandom_range(0, 15) * 2) | ($urandom_range(0, 3) << 9);
                if_req_i = ($urandom % 10) == 0;
            end
            mc_done_i = 1'b0;
            mc_data_i = $urandom;
            if (m_wait) begin
                if (cnt == 0 && en) begin
                    mc_done_i = 1'b1;
                    mc_data_i = mem_word(m_addr);
                    cnt = $urandom_range(0, 3);
                end else if (cnt > 0) begin
                    cnt--;
                end
            end else if (en && ($urandom % 20) == 0) begin
                mc_done_i = 1'b1;
            end

            @(negedge clk);
            xh = model_hit(if_pc_i);
            chk("rnd hit", {31'd0, if_hit_o}, {31'd0, xh});
            chk("rnd mc_req", {31'd0, mc_req_o}, {31'd0, m_wait});
            chk("rnd mc_addr", mc_addr_o, m_addr);
            if (xh) chk("rnd ins", if_ins_o, mem_word(if_pc_i));
            prev_miss = !xh;

            if (rst) begin
                model_reset();
                cnt = 0;
            end else if (en) begin
                if (!m_wait) begin
                    if (if_req_i && !xh) begin
                        m_wait = 1'b1;
                        m_addr = if_pc_i;
                    end
                end else if (mc_done_i) begin
                    i = int'((m_addr >> 1) % 256);
                    m_valid[i] = 1'b1;
                    m_hw[i] = m_addr[31:1];
                    m_wait = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_ins_cache
